// File: rtl/gpio_serial_loader_pkg.sv
// Shared definitions for the GPIO serial loader: default word width,
// FSM state encoding and the bit offsets of each field in a chain word.
package gpio_serial_loader_pkg;

  // Configuration bits carried by one GPIO control block in the chain.
  localparam int GPIO_PAD_CTRL_BITS = 13;

  // Width of the register file address port.
  localparam int GPIO_ADDR_BITS = 6;

  // Bit offsets of each field inside a chain configuration word.
  localparam int MGMT_EN_OFS = 0;
  localparam int OEB_OFS     = 1;
  localparam int HLDH_OFS    = 2;
  localparam int INP_DIS_OFS = 3;
  localparam int MOD_SEL_OFS = 4;
  localparam int AN_EN_OFS   = 5;
  localparam int AN_SEL_OFS  = 6;
  localparam int AN_POL_OFS  = 7;
  localparam int SLOW_OFS    = 8;
  localparam int TRIP_OFS    = 9;
  localparam int DM_OFS      = 10;
  localparam int DM_BITS     = 3;

  // Reset word: management-owned, output disabled, drive mode 3'b001.
  localparam logic [GPIO_PAD_CTRL_BITS-1:0] GPIO_DEFAULT_CFG =
    (13'd1 << MGMT_EN_OFS) | (13'd1 << OEB_OFS) | (13'd1 << DM_OFS);

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  // Counter/index width for a range of n values, never narrower than 1 bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_loader_regfile.sv
// Configuration word storage for the GPIO serial loader.
// One write/read port with range and lock checks, plus a second read
// port used by the serializer while a transfer is in progress.
module gpio_loader_regfile
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_GPIO = 19,
  parameter int PAD_CTRL_BITS = GPIO_PAD_CTRL_BITS,
  parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG = PAD_CTRL_BITS'(GPIO_DEFAULT_CFG)
) (
  input  logic                      serial_clock,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [GPIO_ADDR_BITS-1:0] addr,
  input  logic [PAD_CTRL_BITS-1:0]  wr_data,
  input  logic                      locked,
  input  logic [GPIO_ADDR_BITS-1:0] shift_idx,
  output logic [PAD_CTRL_BITS-1:0]  rd_data,
  output logic [PAD_CTRL_BITS-1:0]  shift_data,
  output logic                      wr_err
);

  localparam int IW = index_width(NUM_GPIO);

  logic [PAD_CTRL_BITS-1:0] mem [NUM_GPIO];
  logic                     addr_ok;

  assign addr_ok = (int'(addr) < NUM_GPIO);

  // Accept writes only when idle and in range; flag every rejected write.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        mem[i] <= DEFAULT_CFG;
      end
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en & (locked | ~addr_ok);
      if (wr_en && !locked && addr_ok) begin
        mem[addr[IW-1:0]] <= wr_data;
      end
    end
  end

  // Host read port: out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      rd_data = mem[addr[IW-1:0]];
    end
  end

  // Serializer read port: the index is always in range by construction.
  assign shift_data = mem[shift_idx[IW-1:0]];

endmodule

// File: rtl/gpio_serial_loader.sv
// GPIO serial loader: shifts NUM_GPIO configuration words down the GPIO
// control block chain, then pulses the chain load strobe.
// Optional build macro GPIO_LOADER_AUTOSTART_EN: when defined, one transfer
// starts by itself in the first cycle after reset release.
//
// Chain handshake: start is a one-cycle request honoured only in IDLE.
// busy is high from the cycle after acceptance through DONE; done pulses
// for one cycle at the end. serial_data_out/serial_clock_en change on the
// falling edge so they are stable at every rising edge the chain sees.
module gpio_serial_loader
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_GPIO = 19,
  parameter int PAD_CTRL_BITS = GPIO_PAD_CTRL_BITS,
  parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG = PAD_CTRL_BITS'(GPIO_DEFAULT_CFG)
) (
  input  logic                      serial_clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      cfg_wr_en,
  input  logic [GPIO_ADDR_BITS-1:0] cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]  cfg_wr_data,
  output logic [PAD_CTRL_BITS-1:0]  cfg_rd_data,
  output logic                      cfg_wr_err,
  output logic                      busy,
  output logic                      done,
  output logic                      serial_data_out,
  output logic                      serial_clock_en,
  output logic                      serial_load
);

  localparam int BW = index_width(PAD_CTRL_BITS);

  loader_state_t             state;
  logic [BW-1:0]             bit_cnt;
  logic [GPIO_ADDR_BITS-1:0] word_cnt;
  logic                      load_cnt;
  logic                      start_eff;
  logic [GPIO_ADDR_BITS-1:0] shift_idx;
  logic [BW-1:0]             bit_sel;
  logic [PAD_CTRL_BITS-1:0]  shift_data;
  logic                      shift_bit;

`ifdef GPIO_LOADER_AUTOSTART_EN
  logic auto_pending;

  // Armed by reset, consumed in the first cycle after release.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      auto_pending <= 1'b1;
    end else begin
      auto_pending <= 1'b0;
    end
  end

  assign start_eff = start | auto_pending;
`else
  assign start_eff = start;
`endif

  // Highest word goes first, MSB first, so block k ends up with word k.
  assign shift_idx = GPIO_ADDR_BITS'(NUM_GPIO - 1) - word_cnt;
  assign bit_sel   = BW'(PAD_CTRL_BITS - 1) - bit_cnt;
  assign shift_bit = shift_data[bit_sel];

  gpio_loader_regfile #(
    .NUM_GPIO      (NUM_GPIO),
    .PAD_CTRL_BITS (PAD_CTRL_BITS),
    .DEFAULT_CFG   (DEFAULT_CFG)
  ) u_regfile (
    .serial_clock (serial_clock),
    .resetn       (resetn),
    .wr_en        (cfg_wr_en),
    .addr         (cfg_addr),
    .wr_data      (cfg_wr_data),
    .locked       (state != ST_IDLE),
    .shift_idx    (shift_idx),
    .rd_data      (cfg_rd_data),
    .shift_data   (shift_data),
    .wr_err       (cfg_wr_err)
  );

  // Transfer sequencer with its registered status and load outputs.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      load_cnt    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      serial_load <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start_eff) begin
            state    <= ST_SHIFT;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == BW'(PAD_CTRL_BITS - 1)) begin
            bit_cnt <= '0;
            if (word_cnt == GPIO_ADDR_BITS'(NUM_GPIO - 1)) begin
              word_cnt    <= '0;
              state       <= ST_LOAD;
              serial_load <= 1'b1;
              load_cnt    <= 1'b0;
            end else begin
              word_cnt <= word_cnt + GPIO_ADDR_BITS'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_LOAD: begin
          if (load_cnt) begin
            state       <= ST_DONE;
            serial_load <= 1'b0;
            done        <= 1'b1;
            load_cnt    <= 1'b0;
          end else begin
            load_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Falling-edge launch of chain data and clock enable (glitch-free gate).
  always_ff @(negedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      serial_data_out <= 1'b0;
      serial_clock_en <= 1'b0;
    end else begin
      serial_clock_en <= (state == ST_SHIFT);
      serial_data_out <= (state == ST_SHIFT) ? shift_bit : 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader with a two-block chain model.
module tb_gpio_serial_loader;

  localparam int NG = 2;
  localparam int PB = 13;
  localparam logic [PB-1:0] DEF = 13'h0403;

  logic          serial_clock;
  logic          resetn;
  logic          start;
  logic          cfg_wr_en;
  logic [5:0]    cfg_addr;
  logic [PB-1:0] cfg_wr_data;
  logic [PB-1:0] cfg_rd_data;
  logic          cfg_wr_err;
  logic          busy;
  logic          done;
  logic          serial_data_out;
  logic          serial_clock_en;
  logic          serial_load;

  gpio_serial_loader #(
    .NUM_GPIO      (NG),
    .PAD_CTRL_BITS (PB),
    .DEFAULT_CFG   (DEF)
  ) dut (
    .serial_clock    (serial_clock),
    .resetn          (resetn),
    .start           (start),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_addr        (cfg_addr),
    .cfg_wr_data     (cfg_wr_data),
    .cfg_rd_data     (cfg_rd_data),
    .cfg_wr_err      (cfg_wr_err),
    .busy            (busy),
    .done            (done),
    .serial_data_out (serial_data_out),
    .serial_clock_en (serial_clock_en),
    .serial_load     (serial_load)
  );

  // Clock and reset
  initial serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  int checks = 0;
  int failures = 0;

  // Chain model and scoreboard state
  logic [2*PB-1:0] chain;
  logic [PB-1:0]   blk0;
  logic [PB-1:0]   blk1;
  int              load_cycles = 0;
  int              done_pulses = 0;
  logic [0:0]      got_q[$];
  logic [0:0]      exp_q[$];
  logic [PB-1:0]   exp_words [NG];

  // Two GPIO blocks: block 0 takes serial data, block 1 follows it.
  always @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
      blk0  <= DEF;
      blk1  <= DEF;
    end else begin
      if (serial_clock_en) begin
        chain <= {chain[2*PB-2:0], serial_data_out};
        got_q.push_back(serial_data_out);
      end
      if (serial_load) begin
        blk0 <= chain[PB-1:0];
        blk1 <= chain[2*PB-1:PB];
        load_cycles++;
      end
      if (done) done_pulses++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge serial_clock);
    #2;
  endtask

  // Driver tasks
  task automatic cfg_write(input logic [5:0] a, input logic [PB-1:0] d, output logic err);
    cfg_wr_en   = 1'b1;
    cfg_addr    = a;
    cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
    err = cfg_wr_err;
  endtask

  task automatic check_read(input string tag, input logic [5:0] a, input logic [PB-1:0] exp);
    cfg_addr = a;
    #1;
    check_eq(tag, cfg_rd_data, exp);
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int w = NG - 1; w >= 0; w--) begin
      for (int b = PB - 1; b >= 0; b--) begin
        exp_q.push_back(exp_words[w][b]);
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    build_exp();
    check_eq({tag, "_nbits"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check_eq($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, done, 1);
  endtask

  task automatic assert_reset();
    resetn    = 1'b0;
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wr_err", cfg_wr_err, 0);
    check_eq("rst_sdo", serial_data_out, 0);
    check_eq("rst_clk_en", serial_clock_en, 0);
    check_eq("rst_load", serial_load, 0);
    for (int w = 0; w < NG; w++) exp_words[w] = DEF;
  endtask

  task automatic release_reset();
    repeat (2) tick();
    resetn = 1'b1;
    got_q.delete();
`ifdef GPIO_LOADER_AUTOSTART_EN
    begin
      int d0;
      d0 = done_pulses;
      tick();
      check_eq("auto_busy", busy, 1);
      wait_done("auto");
      tick();
      check_eq("auto_idle", busy, 0);
      compare_stream("auto");
      repeat (20) tick();
      check_eq("auto_once", done_pulses - d0, 1);
      got_q.delete();
    end
`endif
  endtask

  task automatic run_transfer(input string tag, input bit mid_write);
    int n;
    int d0;
    int l0;
    d0 = done_pulses;
    l0 = load_cycles;
    got_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy_after_start"}, busy, 1);
    check_eq({tag, "_no_early_bit"}, got_q.size(), 0);
    tick();
    check_eq({tag, "_first_bit_latency"}, got_q.size(), 1);
    check_eq({tag, "_clk_en_shift"}, serial_clock_en, 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (mid_write && n == 3) begin
        cfg_wr_en   = 1'b1;
        cfg_addr    = 6'd0;
        cfg_wr_data = '0;
      end
      tick();
      if (mid_write && n == 3) begin
        cfg_wr_en = 1'b0;
        check_eq({tag, "_busy_wr_err"}, cfg_wr_err, 1);
      end
      n++;
    end
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy_in_done"}, busy, 1);
    check_eq({tag, "_load_cycles"}, load_cycles - l0, 2);
    check_eq({tag, "_clk_en_off"}, serial_clock_en, 0);
    tick();
    check_eq({tag, "_busy_low"}, busy, 0);
    check_eq({tag, "_done_low"}, done, 0);
    check_eq({tag, "_done_pulses"}, done_pulses - d0, 1);
    compare_stream(tag);
    check_eq({tag, "_blk0"}, blk0, exp_words[0]);
    check_eq({tag, "_blk1"}, blk1, exp_words[1]);
    check_read({tag, "_word0_kept"}, 6'd0, exp_words[0]);
  endtask

  // Directed sequence
  initial begin
    logic err;
    int d0;
    int l0;
    int n;
    resetn      = 1'b1;
    start       = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_addr    = '0;
    cfg_wr_data = '0;
    #1;

    // Reset state and default contents
    assert_reset();
    release_reset();
    check_read("rd_def0", 6'd0, DEF);
    check_read("rd_def1", 6'd1, DEF);
    check_read("rd_oor2", 6'd2, 13'h0000);
    check_read("rd_oor63", 6'd63, 13'h0000);
    check_eq("idle_busy", busy, 0);

    // Register file writes and range rejection
    cfg_write(6'd0, 13'h1ABC, err);
    check_eq("wr0_err", err, 0);
    exp_words[0] = 13'h1ABC;
    cfg_write(6'd1, 13'h0555, err);
    check_eq("wr1_err", err, 0);
    exp_words[1] = 13'h0555;
    check_read("rd_w0", 6'd0, 13'h1ABC);
    check_read("rd_w1", 6'd1, 13'h0555);
    cfg_write(6'd2, 13'h1FFF, err);
    check_eq("wr_oor_err", err, 1);
    tick();
    check_eq("wr_err_one_cycle", cfg_wr_err, 0);
    check_read("rd_w0_after_oor", 6'd0, 13'h1ABC);
    check_read("rd_w1_after_oor", 6'd1, 13'h0555);
    check_read("rd_oor2_after", 6'd2, 13'h0000);

    // Plain transfer, then one with a write attempt during SHIFT
    run_transfer("xfer", 1'b0);
    run_transfer("xfer_wr", 1'b1);

    // start held high across a transfer: exactly one restart after IDLE
    d0 = done_pulses;
    got_q.delete();
    start = 1'b1;
    wait_done("hold1");
    tick();
    check_eq("hold_idle_gap", busy, 0);
    tick();
    check_eq("hold_restart", busy, 1);
    wait_done("hold2");
    start = 1'b0;
    tick();
    check_eq("hold_end_idle", busy, 0);
    repeat (40) tick();
    check_eq("hold_done_count", done_pulses - d0, 2);
    check_eq("hold_bit_count", got_q.size(), 2 * NG * PB);

    // Reset at bit 10 of SHIFT: immediate abort, no load strobe
    l0 = load_cycles;
    got_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (got_q.size() < 10 && n < 50) begin
      tick();
      n++;
    end
    check_eq("mid_reached_bit10", got_q.size(), 10);
    assert_reset();
    repeat (3) tick();
    check_eq("mid_no_load", load_cycles - l0, 0);
    check_eq("mid_sdo_held", serial_data_out, 0);
    release_reset();
    tick();
    check_eq("mid_idle_after", busy, 0);
    check_read("mid_rd_def0", 6'd0, DEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
